// File: rtl/lane_hit_judge.sv
// Hit judge for the falling-block lanes: grades key presses against each lane's
// block height, detects missed blocks and keeps score/combo/miss statistics.
module lane_hit_judge #(
  parameter int LANES      = 4,
  parameter int HIT_LO     = 600,
  parameter int HIT_HI     = 690,
  parameter int PERF_LO    = 630,
  parameter int PERF_HI    = 660,
  parameter int MISS_LIMIT = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  restart,
  input  logic                  stop_or_endgame,
  input  logic [10*LANES-1:0]   block_h_bus,
  input  logic [LANES-1:0]      key,
  output logic [13:0]           score,
  output logic [6:0]            combo,
  output logic [6:0]            max_combo,
  output logic [6:0]            miss_cnt,
  output logic [1:0]            judge,
  output logic [1:0]            judge_lane,
  output logic                  game_over
);

  localparam logic [9:0] H_IDLE  = 10'd720;
  localparam logic [9:0] HLO_C   = 10'(HIT_LO);
  localparam logic [9:0] HHI_C   = 10'(HIT_HI);
  localparam logic [9:0] PLO_C   = 10'(PERF_LO);
  localparam logic [9:0] PHI_C   = 10'(PERF_HI);
  localparam logic [6:0] MLIM_C  = 7'(MISS_LIMIT);

  localparam logic [1:0] J_NONE = 2'd0;
  localparam logic [1:0] J_PERF = 2'd1;
  localparam logic [1:0] J_GOOD = 2'd2;
  localparam logic [1:0] J_BAD  = 2'd3;

  typedef enum logic {IDLE, ARMED} lane_st_t;

  lane_st_t         st_q     [LANES];
  lane_st_t         st_d     [LANES];
  logic [9:0]       prev_h_q [LANES];
  logic [9:0]       prev_h_d [LANES];
  logic [LANES-1:0] key_q, key_d;
  logic [13:0]      score_q, score_d;
  logic [6:0]       combo_q, combo_d;
  logic [6:0]       max_combo_q, max_combo_d;
  logic [6:0]       miss_cnt_q, miss_cnt_d;
  logic [1:0]       judge_q, judge_d;
  logic [1:0]       judge_lane_q, judge_lane_d;
  logic             game_over_q, game_over_d;

  logic [9:0]       h        [LANES];
  logic [1:0]       evt      [LANES];
  logic [LANES-1:0] press;
  logic [LANES-1:0] is_miss;
  logic             frozen;
  logic             any_err;
  logic             found;
  logic [3:0]       n_perf, n_good, n_miss;
  logic [14:0]      score_sum;
  logic [7:0]       combo_sum;
  logic [7:0]       miss_sum;

  function automatic logic [13:0] sat_score(input logic [14:0] s);
    return (s > 15'd9999) ? 14'd9999 : s[13:0];
  endfunction

  function automatic logic [6:0] sat_u7(input logic [7:0] v, input logic [6:0] lim);
    return (v > {1'b0, lim}) ? lim : v[6:0];
  endfunction

  always_comb begin
    frozen  = stop_or_endgame | game_over_q;
    key_d   = key;
    press   = key & ~key_q;
    is_miss = '0;
    for (int i = 0; i < LANES; i++) begin
      h[i]        = block_h_bus[10*i +: 10];
      prev_h_d[i] = h[i];
      st_d[i]     = st_q[i];
      evt[i]      = J_NONE;
      if (!frozen) begin
        if (st_q[i] == ARMED) begin
          if (h[i] == H_IDLE) begin
            evt[i] = J_BAD; is_miss[i] = 1'b1; st_d[i] = IDLE;
          end else if (h[i] < prev_h_q[i]) begin
            // old block replaced before reaching the line; the new one stays armed
            evt[i] = J_BAD; is_miss[i] = 1'b1;
          end else if (press[i] && h[i] >= PLO_C && h[i] <= PHI_C) begin
            evt[i] = J_PERF; st_d[i] = IDLE;
          end else if (press[i] && h[i] >= HLO_C && h[i] <= HHI_C) begin
            evt[i] = J_GOOD; st_d[i] = IDLE;
          end else if (press[i]) begin
            evt[i] = J_BAD;
          end
        end else begin
          if (h[i] < prev_h_q[i]) st_d[i] = ARMED;
          if (press[i]) evt[i] = J_BAD;
        end
      end
    end

    n_perf       = '0;
    n_good       = '0;
    n_miss       = '0;
    any_err      = 1'b0;
    found        = 1'b0;
    judge_d      = judge_q;
    judge_lane_d = judge_lane_q;
    for (int i = 0; i < LANES; i++) begin
      if (evt[i] == J_PERF) n_perf = n_perf + 4'd1;
      if (evt[i] == J_GOOD) n_good = n_good + 4'd1;
      if (is_miss[i])       n_miss = n_miss + 4'd1;
      if (evt[i] == J_BAD)  any_err = 1'b1;
      if (!found && evt[i] != J_NONE) begin
        found        = 1'b1;
        judge_d      = evt[i];
        judge_lane_d = 2'(i);
      end
    end

    score_sum   = {1'b0, score_q} + 15'(n_perf) * 15'd3 + 15'(n_good);
    score_d     = sat_score(score_sum);
    combo_sum   = {1'b0, combo_q} + 8'(n_perf) + 8'(n_good);
    combo_d     = any_err ? 7'd0 : sat_u7(combo_sum, 7'd99);
    max_combo_d = (combo_d > max_combo_q) ? combo_d : max_combo_q;
    miss_sum    = {1'b0, miss_cnt_q} + 8'(n_miss);
    miss_cnt_d  = sat_u7(miss_sum, 7'd127);
    game_over_d = game_over_q | (miss_cnt_q >= MLIM_C);
  end

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      for (int i = 0; i < LANES; i++) begin
        st_q[i]     <= IDLE;
        prev_h_q[i] <= H_IDLE;
      end
      key_q        <= '0;
      score_q      <= '0;
      combo_q      <= '0;
      max_combo_q  <= '0;
      miss_cnt_q   <= '0;
      judge_q      <= J_NONE;
      judge_lane_q <= '0;
      game_over_q  <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        st_q[i]     <= st_d[i];
        prev_h_q[i] <= prev_h_d[i];
      end
      key_q        <= key_d;
      score_q      <= score_d;
      combo_q      <= combo_d;
      max_combo_q  <= max_combo_d;
      miss_cnt_q   <= miss_cnt_d;
      judge_q      <= judge_d;
      judge_lane_q <= judge_lane_d;
      game_over_q  <= game_over_d;
    end
  end

  assign score      = score_q;
  assign combo      = combo_q;
  assign max_combo  = max_combo_q;
  assign miss_cnt   = miss_cnt_q;
  assign judge      = judge_q;
  assign judge_lane = judge_lane_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_lane_hit_judge.sv
// Directed bench for lane_hit_judge: the driver queues hand-computed expected
// outputs per cycle, a monitor pops and compares them after each clock edge.
module tb_lane_hit_judge;

  logic        clk = 1'b0;
  logic        rst, restart, stop_or_endgame;
  logic [39:0] block_h_bus;
  logic [3:0]  key;
  logic [13:0] score;
  logic [6:0]  combo, max_combo, miss_cnt;
  logic [1:0]  judge, judge_lane;
  logic        game_over;
  logic [9:0]  h [4];

  typedef struct {
    logic [13:0] score;
    logic [6:0]  combo, maxc, miss;
    logic [1:0]  judge, jl;
    logic        go;
    int          id;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   step_id = 0;
  bit   drv_done = 1'b0;

  lane_hit_judge dut (
    .clk(clk), .rst(rst), .restart(restart), .stop_or_endgame(stop_or_endgame),
    .block_h_bus(block_h_bus), .key(key), .score(score), .combo(combo),
    .max_combo(max_combo), .miss_cnt(miss_cnt), .judge(judge),
    .judge_lane(judge_lane), .game_over(game_over)
  );

  always #5 clk = ~clk;
  assign block_h_bus = {h[3], h[2], h[1], h[0]};

  task automatic cyc(input int s, input int c, input int mx, input int mi,
                     input int j, input int jl, input int go);
    exp_t e;
    e.score = 14'(s); e.combo = 7'(c); e.maxc = 7'(mx); e.miss = 7'(mi);
    e.judge = 2'(j);  e.jl = 2'(jl);   e.go = 1'(go);   e.id = step_id;
    step_id++;
    @(posedge clk);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic set_h(input int a, input int b, input int c, input int d);
    h[0] = 10'(a); h[1] = 10'(b); h[2] = 10'(c); h[3] = 10'(d);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        total++;
        if (score !== x.score || combo !== x.combo || max_combo !== x.maxc ||
            miss_cnt !== x.miss || judge !== x.judge || judge_lane !== x.jl ||
            game_over !== x.go) begin
          bad++;
          $display("FAIL step%0d: got score=%0d combo=%0d max=%0d miss=%0d judge=%0d lane=%0d go=%0d, want score=%0d combo=%0d max=%0d miss=%0d judge=%0d lane=%0d go=%0d",
                   x.id, score, combo, max_combo, miss_cnt, judge, judge_lane, game_over,
                   x.score, x.combo, x.maxc, x.miss, x.judge, x.jl, x.go);
        end
      end
    end
  end

  initial begin : driver
    rst = 1'b1; restart = 1'b0; stop_or_endgame = 1'b0; key = 4'b0000;
    set_h(720, 720, 720, 720);
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    // lane0 perfect, then a second press on the now idle lane is BAD
    h[0] = 120;               cyc(0, 0, 0, 0, 0, 0, 0);
    h[0] = 645;               cyc(0, 0, 0, 0, 0, 0, 0);
    key = 4'b0001;            cyc(3, 1, 1, 0, 1, 0, 0);
    key = 4'b0000; h[0] = 650; cyc(3, 1, 1, 0, 1, 0, 0);
    key = 4'b0001;            cyc(3, 0, 1, 0, 3, 0, 0);
    key = 4'b0000; h[0] = 720; cyc(3, 0, 1, 0, 3, 0, 0);
    // lane1 GOOD at 605
    h[1] = 120;               cyc(3, 0, 1, 0, 3, 0, 0);
    h[1] = 605; key = 4'b0010; cyc(4, 1, 1, 0, 2, 1, 0);
    key = 4'b0000; h[1] = 720; cyc(4, 1, 1, 0, 2, 1, 0);
    // lane1 BAD at 595, block stays armed and then misses
    h[1] = 120;               cyc(4, 1, 1, 0, 2, 1, 0);
    h[1] = 595; key = 4'b0010; cyc(4, 0, 1, 0, 3, 1, 0);
    key = 4'b0000; h[1] = 720; cyc(4, 0, 1, 1, 3, 1, 0);
    // lanes 0 and 2 perfect together
    h[0] = 120; h[2] = 120;   cyc(4, 0, 1, 1, 3, 1, 0);
    h[0] = 640; h[2] = 640; key = 4'b0101; cyc(10, 2, 2, 1, 1, 0, 0);
    key = 4'b0000; h[0] = 720; h[2] = 720; cyc(10, 2, 2, 1, 1, 0, 0);
    // lane0 perfect with lane3 miss in the same cycle
    h[0] = 120; h[3] = 120;   cyc(10, 2, 2, 1, 1, 0, 0);
    h[0] = 640; h[3] = 650;   cyc(10, 2, 2, 1, 1, 0, 0);
    key = 4'b0001; h[3] = 720; cyc(13, 0, 2, 2, 1, 0, 0);
    key = 4'b0000; h[0] = 720; cyc(13, 0, 2, 2, 1, 0, 0);
    // replaced block counts a miss, new block still hittable
    h[2] = 120;               cyc(13, 0, 2, 2, 1, 0, 0);
    h[2] = 500;               cyc(13, 0, 2, 2, 1, 0, 0);
    h[2] = 120;               cyc(13, 0, 2, 3, 3, 2, 0);
    h[2] = 640; key = 4'b0100; cyc(16, 1, 2, 3, 1, 2, 0);
    key = 4'b0000; h[2] = 720; cyc(16, 1, 2, 3, 1, 2, 0);
    // window edges on lane1: 630 perfect, 690 good, 691 bad then miss
    h[1] = 120;               cyc(16, 1, 2, 3, 1, 2, 0);
    h[1] = 630; key = 4'b0010; cyc(19, 2, 2, 3, 1, 1, 0);
    key = 4'b0000; h[1] = 720; cyc(19, 2, 2, 3, 1, 1, 0);
    h[1] = 120;               cyc(19, 2, 2, 3, 1, 1, 0);
    h[1] = 690; key = 4'b0010; cyc(20, 3, 3, 3, 2, 1, 0);
    key = 4'b0000; h[1] = 720; cyc(20, 3, 3, 3, 2, 1, 0);
    h[1] = 120;               cyc(20, 3, 3, 3, 2, 1, 0);
    h[1] = 691; key = 4'b0010; cyc(20, 0, 3, 3, 3, 1, 0);
    key = 4'b0000; h[1] = 720; cyc(20, 0, 3, 4, 3, 1, 0);
    // key held through a freeze does not fire on resume
    h[0] = 120;               cyc(20, 0, 3, 4, 3, 1, 0);
    h[0] = 640; stop_or_endgame = 1'b1; key = 4'b0001; cyc(20, 0, 3, 4, 3, 1, 0);
    stop_or_endgame = 1'b0;   cyc(20, 0, 3, 4, 3, 1, 0);
    key = 4'b0000;            cyc(20, 0, 3, 4, 3, 1, 0);
    key = 4'b0001;            cyc(23, 1, 3, 4, 1, 0, 0);
    key = 4'b0000; h[0] = 720; cyc(23, 1, 3, 4, 1, 0, 0);
    // new block arriving while frozen is not armed after resume
    stop_or_endgame = 1'b1; h[3] = 120; cyc(23, 1, 3, 4, 1, 0, 0);
    stop_or_endgame = 1'b0;   cyc(23, 1, 3, 4, 1, 0, 0);
    h[3] = 720;               cyc(23, 1, 3, 4, 1, 0, 0);
    // six more misses reach the limit; game_over follows one cycle later
    set_h(120, 120, 120, 120); cyc(23, 1, 3, 4, 1, 0, 0);
    set_h(720, 720, 720, 720); cyc(23, 0, 3, 8, 3, 0, 0);
    h[0] = 120; h[1] = 120;   cyc(23, 0, 3, 8, 3, 0, 0);
    h[0] = 720; h[1] = 720;   cyc(23, 0, 3, 10, 3, 0, 0);
    cyc(23, 0, 3, 10, 3, 0, 1);
    h[0] = 120;               cyc(23, 0, 3, 10, 3, 0, 1);
    h[0] = 640; key = 4'b0001; cyc(23, 0, 3, 10, 3, 0, 1);
    key = 4'b0000; h[0] = 720; cyc(23, 0, 3, 10, 3, 0, 1);
    restart = 1'b1;           cyc(0, 0, 0, 0, 0, 0, 0);
    restart = 1'b0;           cyc(0, 0, 0, 0, 0, 0, 0);
    // play resumes normally after restart
    h[2] = 120;               cyc(0, 0, 0, 0, 0, 0, 0);
    h[2] = 660; key = 4'b0100; cyc(3, 1, 1, 0, 1, 2, 0);
    key = 4'b0000;
    drv_done = 1'b1;
  end

  initial begin : finisher
    int guard;
    guard = 0;
    while (!drv_done && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!drv_done) begin
      total++; bad++;
      $display("FAIL timeout: got driver unfinished after %0d cycles, want finished", guard);
    end
    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
